fpu_result_collector: RTL and testbench

FPU_RESULT_COLLECTOR -- requirements
Module: fpu_result_collector

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_res_fifo.sv | 51 +++++
 rtl/fpu_result_collector.sv | 170 +++++++++++++++++
 tb/tb_fpu_result_collector.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, operation encodings and the
// result collector state type.
`timescale 1ns/1ps
package fpu_pkg;

  // Bit positions inside the 8-bit fpu_flags word
  localparam int FLAG_SNAN        = 7;
  localparam int FLAG_QNAN        = 6;
  localparam int FLAG_INF         = 5;
  localparam int FLAG_INE         = 4;
  localparam int FLAG_OVERFLOW    = 3;
  localparam int FLAG_UNDERFLOW   = 2;
  localparam int FLAG_DIV_BY_ZERO = 1;
  localparam int FLAG_ZERO        = 0;

  localparam int FPU_FLAGS_W = 8;
  localparam int FPU_OP_W    = 3;

  typedef enum logic [2:0] {
    FPU_OP_ADD = 3'd0,
    FPU_OP_SUB = 3'd1,
    FPU_OP_MUL = 3'd2,
    FPU_OP_DIV = 3'd3
  } fpu_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } coll_state_e;

endpackage

// File: rtl/fpu_res_fifo.sv
// Result FIFO for the FPU collector. Pointers carry one extra wrap bit so
// full and empty fall out of a plain pointer comparison. Storage is not reset.
`timescale 1ns/1ps
module fpu_res_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [PW-1:0]    count
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Advance write/read pointers; they wrap modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage, written at the write pointer slot
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fpu_result_collector.sv
// Collects results from a fixed-latency FPU: a LATENCY-deep valid/op line
// follows each issued op and writes fpu_out/fpu_flags/op into a result FIFO
// when the op leaves the line. Issue is throttled so a capture always finds
// room. flush enters DRAIN until everything in flight and queued has popped.
// Optional: define FPU_COLLECT_CMP_EN to carry an expected value with each op
// and flag/count popped results that differ from it.
`timescale 1ns/1ps
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int BIT_SIZE = 31,
  parameter int LATENCY  = 4,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [2:0]          issue_op,
  output logic                issue_ready,
  input  logic [BIT_SIZE:0]   fpu_out,
  input  logic [7:0]          fpu_flags,
  input  logic                flush,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [BIT_SIZE:0]   res_data,
  output logic [7:0]          res_flags,
  output logic [2:0]          res_op,
  output logic                drain_done
`ifdef FPU_COLLECT_CMP_EN
  ,
  input  logic [BIT_SIZE:0]   issue_exp,
  output logic                res_mismatch,
  output logic [15:0]         mismatch_cnt
`endif
);

  localparam int DW = BIT_SIZE + 1;
  localparam int PW = $clog2(DEPTH) + 1;
`ifdef FPU_COLLECT_CMP_EN
  localparam int EW = DW + DW + 11;
`else
  localparam int EW = DW + 11;
`endif

  logic [LATENCY-1:0] line_vld_p;
  logic [2:0]         line_op_p [LATENCY];
`ifdef FPU_COLLECT_CMP_EN
  logic [BIT_SIZE:0]  line_exp_p [LATENCY];
  logic [BIT_SIZE:0]  head_exp;
`endif
  coll_state_e        state;
  logic               issue_fire;
  logic               cap_en;
  logic               pop_en;
  logic               fifo_empty;
  logic [PW-1:0]      fifo_count;
  logic [PW-1:0]      inflight;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      head;
  logic [BIT_SIZE:0]  head_data;
  logic [7:0]         head_flags;
  logic [2:0]         head_op;

  function automatic logic [PW-1:0] count_inflight(input logic [LATENCY-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < LATENCY; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // Issue only while running and while in-flight plus queued leaves a free slot
  assign inflight    = count_inflight(line_vld_p);
  assign issue_ready = (state == ST_RUN) &&
                       (({1'b0, inflight} + {1'b0, fifo_count}) < (PW+1)'(DEPTH));
  assign issue_fire  = issue_valid && issue_ready;
  assign cap_en      = line_vld_p[LATENCY-1];
  assign res_valid   = !fifo_empty;
  assign pop_en      = res_valid && res_ready;

  // Valid tracking line: p0 takes the issue, the last stage marks the capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_vld_p <= '0;
    end else begin
      line_vld_p[0] <= issue_fire;
      for (int i = 1; i < LATENCY; i++) line_vld_p[i] <= line_vld_p[i-1];
    end
  end

  // Op (and expected value) ride alongside the valid bits; not reset
  always_ff @(posedge clk) begin
    line_op_p[0] <= issue_op;
    for (int i = 1; i < LATENCY; i++) line_op_p[i] <= line_op_p[i-1];
`ifdef FPU_COLLECT_CMP_EN
    line_exp_p[0] <= issue_exp;
    for (int i = 1; i < LATENCY; i++) line_exp_p[i] <= line_exp_p[i-1];
`endif
  end

  // ---- capture stage: line exit -> FIFO entry ----
`ifdef FPU_COLLECT_CMP_EN
  assign wr_entry = {line_exp_p[LATENCY-1], fpu_flags, fpu_out, line_op_p[LATENCY-1]};
  assign head_exp = head[EW-1:DW+11];
`else
  assign wr_entry = {fpu_flags, fpu_out, line_op_p[LATENCY-1]};
`endif

  fpu_res_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_en),
    .wr_data (wr_entry),
    .rd_en   (pop_en),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---- output stage: FIFO head, zeroed while nothing is valid ----
  assign head_op    = head[2:0];
  assign head_data  = head[DW+2:3];
  assign head_flags = head[DW+10:DW+3];
  assign res_data   = res_valid ? head_data  : '0;
  assign res_flags  = res_valid ? head_flags : '0;
  assign res_op     = res_valid ? head_op    : '0;

  // RUN/DRAIN control with a registered one-cycle drain_done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((inflight == '0) && fifo_empty) begin
            state      <= ST_RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef FPU_COLLECT_CMP_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign res_mismatch = res_valid && (head_data != head_exp);

  // Count popped results that disagree with their expected value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
    end else if (pop_en && res_mismatch) begin
      mismatch_cnt <= sat_inc16(mismatch_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: directed scenarios plus a randomized run,
// checked against a queue-based model of in-flight ops and queued results.
`timescale 1ns/1ps
module tb_fpu_result_collector;
  import fpu_pkg::*;

  localparam int BS  = 31;
  localparam int LAT = 4;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [2:0]    issue_op = '0;
  logic          issue_ready;
  logic [BS:0]   fpu_out = '0;
  logic [7:0]    fpu_flags = '0;
  logic          flush = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [BS:0]   res_data;
  logic [7:0]    res_flags;
  logic [2:0]    res_op;
  logic          drain_done;
  logic [BS:0]   issue_exp = '0;
`ifdef FPU_COLLECT_CMP_EN
  logic          res_mismatch;
  logic [15:0]   mismatch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { int cap; logic [2:0] op; logic [BS:0] exp; } fly_t;
  typedef struct { logic [BS:0] data; logic [7:0] flags; logic [2:0] op; logic [BS:0] exp; } ent_t;

  fly_t fly_q[$];
  ent_t fifo_q[$];
  int   cyc = 0;
  bit   m_drain = 0;
  bit   m_done = 0;
  int   m_mcnt = 0;

  always #5 clk = ~clk;

  fpu_result_collector #(.BIT_SIZE(BS), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_ready (issue_ready),
    .fpu_out     (fpu_out),
    .fpu_flags   (fpu_flags),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_flags   (res_flags),
    .res_op      (res_op),
    .drain_done  (drain_done)
`ifdef FPU_COLLECT_CMP_EN
    ,
    .issue_exp    (issue_exp),
    .res_mismatch (res_mismatch),
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  function automatic bit m_ready();
    return !m_drain && ((fly_q.size() + fifo_q.size()) < DEP);
  endfunction

  task automatic model_clear();
    fly_q.delete();
    fifo_q.delete();
    m_drain = 0;
    m_done  = 0;
    m_mcnt  = 0;
  endtask

  // Reference behaviour at one rising edge, from the inputs held this cycle
  task automatic model_edge();
    bit   rdy, pop, leave;
    ent_t e;
    fly_t f;
    rdy   = m_ready();
    pop   = (fifo_q.size() > 0) && res_ready;
    leave = m_drain && (fly_q.size() == 0) && (fifo_q.size() == 0);
    cyc++;
    if (pop) begin
      if ((fifo_q[0].data !== fifo_q[0].exp) && (m_mcnt < 65535)) m_mcnt++;
      fifo_q.delete(0);
    end
    if ((fly_q.size() > 0) && (fly_q[0].cap == cyc)) begin
      e.data  = fpu_out;
      e.flags = fpu_flags;
      e.op    = fly_q[0].op;
      e.exp   = fly_q[0].exp;
      fifo_q.push_back(e);
      fly_q.delete(0);
    end
    if (issue_valid && rdy) begin
      f.cap = cyc + LAT;
      f.op  = issue_op;
      f.exp = issue_exp;
      fly_q.push_back(f);
    end
    m_done = leave;
    if (leave) m_drain = 0;
    else if (!m_drain && flush) m_drain = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    fpu_out   = $urandom;
    fpu_flags = 8'($urandom);
  endtask

  task automatic test_reset();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %0b want 0", drain_done); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data); end
    checks++; if (res_flags !== 8'h00) begin errors++; $display("FAIL reset_res_flags got %h want 0", res_flags); end
    checks++; if (res_op !== 3'd0) begin errors++; $display("FAIL reset_res_op got %0d want 0", res_op); end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_single();
    res_ready   = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 3'd3;
    tick();
    issue_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        fpu_out   = 32'h39225e6c;
        fpu_flags = 8'h22;
      end
      tick();
      checks++;
      if (res_valid !== (i == 4)) begin errors++; $display("FAIL single_valid_c%0d got %0b want %0b", i, res_valid, (i == 4)); end
    end
    checks++; if (res_data !== 32'h39225e6c) begin errors++; $display("FAIL single_data got %h want 39225e6c", res_data); end
    checks++; if (res_op !== 3'd3) begin errors++; $display("FAIL single_op got %0d want 3", res_op); end
    checks++; if (res_flags !== 8'h22) begin errors++; $display("FAIL single_flags got %h want 22", res_flags); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %0b want 0", res_valid); end
  endtask

  task automatic test_fill();
    int       acc;
    logic [2:0] ops[$];
    acc = 0;
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue_op = 3'($urandom_range(0, 3));
      checks++;
      if (issue_ready !== (acc < 8)) begin errors++; $display("FAIL fill_ready_c%0d got %0b want %0b", i, issue_ready, (acc < 8)); end
      if (issue_ready) begin
        acc++;
        ops.push_back(issue_op);
      end
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (acc != 8) begin errors++; $display("FAIL fill_accepted got %0d want 8", acc); end
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (res_valid !== 1'b1 || k >= ops.size() || res_op !== ops[k] || fifo_q.size() == 0 || res_data !== fifo_q[0].data) begin
        errors++; $display("FAIL fill_pop%0d got v=%0b op=%0d data=%h want v=1 in-order entry", k, res_valid, res_op, res_data);
      end
      tick();
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got %0b want 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[$];
    int         pops;
    pops = 0;
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue_op = 3'($urandom_range(0, 3));
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d got %0b want 1", i, issue_ready); end
      ops.push_back(issue_op);
      tick();
    end
    issue_valid = 1'b0;
    tick();
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (res_valid !== (i < 6)) begin errors++; $display("FAIL b2b_valid_c%0d got %0b want %0b", i, res_valid, (i < 6)); end
      if (res_valid) begin
        checks++;
        if (pops >= ops.size() || res_op !== ops[pops] || fifo_q.size() == 0 || res_data !== fifo_q[0].data) begin
          errors++; $display("FAIL b2b_pop%0d got op=%0d data=%h want in-order entry", pops, res_op, res_data);
        end
        pops++;
      end
      tick();
    end
    checks++; if (pops != 6) begin errors++; $display("FAIL b2b_pops got %0d want 6", pops); end
    res_ready = 1'b0;
  endtask

  task automatic test_flush();
    int pulses, pops;
    pulses = 0;
    pops   = 0;
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    issue_op    = 3'($urandom_range(0, 3));
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    issue_valid = 1'b1;
    issue_op    = 3'($urandom_range(0, 3));
    tick();
    flush    = 1'b1;
    issue_op = 3'($urandom_range(0, 3));
    tick();
    flush = 1'b0;
    checks++; if (fifo_q.size() != 1 || fly_q.size() != 2) begin errors++; $display("FAIL flush_setup got q=%0d f=%0d want 1 2", fifo_q.size(), fly_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_hold_ready_c%0d got %0b want 0", i, issue_ready); end
      checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL flush_hold_done_c%0d got %0b want 0", i, drain_done); end
      tick();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (drain_done) begin
        pulses++;
        checks++; if (pops != 3) begin errors++; $display("FAIL flush_pops_at_done got %0d want 3", pops); end
      end
      checks++;
      if (issue_ready !== (pulses > 0)) begin errors++; $display("FAIL flush_ready_c%0d got %0b want %0b", i, issue_ready, (pulses > 0)); end
      if (res_valid) begin
        checks++;
        if (fifo_q.size() == 0 || res_data !== fifo_q[0].data || res_op !== fifo_q[0].op) begin
          errors++; $display("FAIL flush_pop%0d got data=%h op=%0d want model head", pops, res_data, res_op);
        end
        pops++;
      end
      if (pulses > 0) issue_valid = 1'b0;
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses got %0d want 1", pulses); end
    checks++; if (pops != 3) begin errors++; $display("FAIL flush_pops got %0d want 3", pops); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_resume got %0b want 1", issue_ready); end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_op = 3'($urandom_range(0, 3));
      tick();
    end
    issue_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0b want 1", res_valid); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", res_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", issue_ready); end
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_c%0d got %0b want 0", i, res_valid); end
    end
    res_ready = 1'b0;
  endtask

`ifdef FPU_COLLECT_CMP_EN
  task automatic test_compare();
    res_ready   = 1'b0;
    issue_valid = 1'b1;
    issue_op    = 3'd2;
    issue_exp   = 32'h4b905b6f;
    tick();
    issue_valid = 1'b0;
    issue_exp   = '0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) fpu_out = 32'h4b905b70;
      tick();
    end
    checks++; if (res_mismatch !== 1'b1) begin errors++; $display("FAIL cmp_mismatch got %0b want 1", res_mismatch); end
    checks++; if (mismatch_cnt !== 16'd0) begin errors++; $display("FAIL cmp_cnt_before got %0d want 0", mismatch_cnt); end
    res_ready = 1'b1;
    tick();
    checks++; if (mismatch_cnt !== 16'd1) begin errors++; $display("FAIL cmp_cnt_after got %0d want 1", mismatch_cnt); end
    res_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_op    = 3'($urandom_range(0, 3));
      issue_exp   = $urandom_range(0, 3);
      fpu_out     = $urandom_range(0, 3);
      res_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (res_valid !== (fifo_q.size() > 0)) begin errors++; $display("FAIL rand_valid_c%0d got %0b want %0b", i, res_valid, (fifo_q.size() > 0)); end
      checks++;
      if (fifo_q.size() > 0) begin
        if (res_data !== fifo_q[0].data || res_flags !== fifo_q[0].flags || res_op !== fifo_q[0].op) begin
          errors++; $display("FAIL rand_head_c%0d got %h/%h/%0d want %h/%h/%0d", i, res_data, res_flags, res_op, fifo_q[0].data, fifo_q[0].flags, fifo_q[0].op);
        end
      end else if (res_data !== '0 || res_flags !== 8'h00 || res_op !== 3'd0) begin
        errors++; $display("FAIL rand_idle_c%0d got %h/%h/%0d want 0/0/0", i, res_data, res_flags, res_op);
      end
      checks++;
      if (issue_ready !== m_ready()) begin errors++; $display("FAIL rand_ready_c%0d got %0b want %0b", i, issue_ready, m_ready()); end
      checks++;
      if (drain_done !== m_done) begin errors++; $display("FAIL rand_done_c%0d got %0b want %0b", i, drain_done, m_done); end
`ifdef FPU_COLLECT_CMP_EN
      checks++;
      if (res_mismatch !== ((fifo_q.size() > 0) && (fifo_q[0].data !== fifo_q[0].exp))) begin
        errors++; $display("FAIL rand_mismatch_c%0d got %0b", i, res_mismatch);
      end
      checks++;
      if (mismatch_cnt !== 16'(m_mcnt)) begin errors++; $display("FAIL rand_mcnt_c%0d got %0d want %0d", i, mismatch_cnt, m_mcnt); end
`endif
    end
    issue_valid = 1'b0;
    flush       = 1'b0;
    res_ready   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef FPU_COLLECT_CMP_EN
    test_compare();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
